// File: rtl/usb_cdc_in_arbiter.sv
// Round-robin burst arbiter that shares the usb_cdc IN byte stream between N_REQ requesters.
// Define USB_CDC_ARB_TAG_EN to prefix every burst with header byte 8'hA0 | owner index.
module usb_cdc_in_arbiter #(
  parameter int N_REQ        = 2,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i
);

  localparam int         IDX_W      = $clog2(N_REQ);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef USB_CDC_ARB_TAG_EN
    ST_TAG  = 2'd2,
`endif
    ST_XFER = 2'd1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last_owner;
  logic [N_REQ-1:0]   r_grant;
  logic [7:0]         r_burst;
  logic [7:0]         r_idle;
  logic [7:0]         r_data;
  logic               r_valid;

  logic               w_pick_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_slot_free;
  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_data;
  logic [N_REQ-1:0]   w_ready;
  logic               w_accept;
  logic               w_load_hdr;
  logic               w_grant_load;
  logic               w_release;
  logic               w_idle_inc;

  // The output register can take a new byte when empty or when its byte leaves this edge.
  assign w_slot_free = ~r_valid | in_ready_i;
  assign w_own_valid = req_valid_i[r_owner];
  assign w_own_last  = req_last_i[r_owner];
  assign w_own_data  = req_data_i[int'(r_owner)*8 +: 8];

  // Round-robin search upward from the requester after the previous owner.
  always_comb begin
    int k;
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    k            = 0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(r_last_owner) + i) % N_REQ;
      if (!w_pick_found && req_valid_i[k]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = '0;
    w_accept     = 1'b0;
    w_load_hdr   = 1'b0;
    w_grant_load = 1'b0;
    w_release    = 1'b0;
    w_idle_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_grant_load = 1'b1;
`ifdef USB_CDC_ARB_TAG_EN
          w_state_nxt  = ST_TAG;
`else
          w_state_nxt  = ST_XFER;
`endif
        end
      end
`ifdef USB_CDC_ARB_TAG_EN
      ST_TAG: begin
        if (w_slot_free) begin
          w_load_hdr  = 1'b1;
          w_state_nxt = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        w_ready  = r_grant & {N_REQ{w_slot_free}};
        w_accept = w_own_valid & w_slot_free;
        if (w_accept) begin
          w_release = w_own_last | (r_burst == BURST_LAST);
        end else if (!w_own_valid) begin
          w_idle_inc = 1'b1;
          w_release  = (r_idle == IDLE_LAST);
        end
        if (w_release) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(N_REQ - 1);
      r_grant      <= '0;
      r_burst      <= '0;
      r_idle       <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      r_state <= w_state_nxt;
      if (w_grant_load) begin
        r_owner <= w_pick_idx;
        r_grant <= N_REQ'(1) << w_pick_idx;
        r_burst <= '0;
        r_idle  <= '0;
      end
      if (w_release) begin
        r_grant      <= '0;
        r_last_owner <= r_owner;
      end
      if (w_accept) begin
        r_burst <= r_burst + 8'd1;
        r_idle  <= '0;
      end else if (w_idle_inc) begin
        r_idle  <= r_idle + 8'd1;
      end
      if (w_accept) begin
        r_data  <= w_own_data;
        r_valid <= 1'b1;
      end else if (w_load_hdr) begin
        r_data  <= 8'hA0 | 8'(r_owner);
        r_valid <= 1'b1;
      end else if (in_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign req_ready_o = w_ready;
  assign grant_o     = r_grant;
  assign in_data_o   = r_data;
  assign in_valid_o  = r_valid;

endmodule

// File: tb/tb_usb_cdc_in_arbiter.sv
// Directed bench for usb_cdc_in_arbiter (N_REQ=2, MAX_BURST=8, IDLE_TIMEOUT=16).
module tb_usb_cdc_in_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  grant_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;

  usb_cdc_in_arbiter #(.N_REQ(2), .MAX_BURST(8), .IDLE_TIMEOUT(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    req_valid_i = 2'b00;
    req_last_i  = 2'b00;
    req_data_i  = 16'h0000;
    in_ready_i  = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [1:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [1:0] e_grant;
    logic [1:0] e_ready;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [1:0] l, logic [7:0] d0, logic [7:0] d1,
                              logic rdy, logic [1:0] eg, logic [1:0] er, logic ev, logic [7:0] ed);
    vec_t r;
    r.valid = v;  r.last = l;  r.d0 = d0;  r.d1 = d1;  r.rdy = rdy;
    r.e_grant = eg;  r.e_ready = er;  r.e_valid = ev;  r.e_data = ed;
    return r;
  endfunction

  // Expected byte g of the continuous two-requester stream: alternating 8-byte bursts.
  function automatic logic [7:0] stream_byte(int g);
    int b;
    int pos;
    b   = g / 8;
    pos = g % 8;
    if (b % 2 == 0) return 8'((b / 2) * 8 + pos);
    else            return 8'(8'h80 + (b / 2) * 8 + pos);
  endfunction

  vec_t       vecs[28];
  logic [7:0] cnt0, cnt1;
  logic [1:0] acc;
  logic [7:0] got_bytes[4];
  int         got;
  int         n;

  initial begin
    // Inputs applied for one cycle; expectations are what the outputs show in that cycle.
    vecs[0]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 0, 8'h00);
    vecs[1]  = mk(2'b01, 2'b00, 8'h11, 8'h00, 1, 2'b00, 2'b00, 0, 8'h00);
    vecs[2]  = mk(2'b01, 2'b00, 8'h11, 8'h00, 1, 2'b01, 2'b01, 0, 8'h00);
    vecs[3]  = mk(2'b01, 2'b00, 8'h22, 8'h00, 1, 2'b01, 2'b01, 1, 8'h11);
    vecs[4]  = mk(2'b01, 2'b01, 8'h33, 8'h00, 1, 2'b01, 2'b01, 1, 8'h22);
    vecs[5]  = mk(2'b00, 2'b00, 8'h33, 8'h00, 1, 2'b00, 2'b00, 1, 8'h33);
    vecs[6]  = mk(2'b00, 2'b00, 8'h33, 8'h00, 1, 2'b00, 2'b00, 0, 8'h33);
    vecs[7]  = mk(2'b11, 2'b00, 8'h40, 8'h71, 1, 2'b00, 2'b00, 0, 8'h33);
    vecs[8]  = mk(2'b11, 2'b00, 8'h40, 8'h71, 1, 2'b10, 2'b10, 0, 8'h33);
    for (int i = 9; i <= 13; i++)
      vecs[i] = mk(2'b11, 2'b00, 8'h40, 8'h72, 0, 2'b10, 2'b00, 1, 8'h71);
    vecs[14] = mk(2'b11, 2'b00, 8'h40, 8'h72, 1, 2'b10, 2'b10, 1, 8'h71);
    vecs[15] = mk(2'b11, 2'b10, 8'h40, 8'h73, 1, 2'b10, 2'b10, 1, 8'h72);
    vecs[16] = mk(2'b01, 2'b00, 8'h40, 8'h73, 1, 2'b00, 2'b00, 1, 8'h73);
    vecs[17] = mk(2'b01, 2'b00, 8'h40, 8'h73, 1, 2'b01, 2'b01, 0, 8'h73);
    vecs[18] = mk(2'b01, 2'b01, 8'h41, 8'h73, 1, 2'b01, 2'b01, 1, 8'h40);
    vecs[19] = mk(2'b00, 2'b00, 8'h41, 8'h73, 1, 2'b00, 2'b00, 1, 8'h41);
    vecs[20] = mk(2'b00, 2'b00, 8'h41, 8'h73, 1, 2'b00, 2'b00, 0, 8'h41);
    vecs[21] = mk(2'b10, 2'b10, 8'h41, 8'h55, 1, 2'b00, 2'b00, 0, 8'h41);
    vecs[22] = mk(2'b10, 2'b10, 8'h41, 8'h55, 0, 2'b10, 2'b10, 0, 8'h41);
    vecs[23] = mk(2'b01, 2'b01, 8'h66, 8'h55, 0, 2'b00, 2'b00, 1, 8'h55);
    vecs[24] = mk(2'b01, 2'b01, 8'h66, 8'h55, 0, 2'b01, 2'b00, 1, 8'h55);
    vecs[25] = mk(2'b01, 2'b01, 8'h66, 8'h55, 1, 2'b01, 2'b01, 1, 8'h55);
    vecs[26] = mk(2'b00, 2'b00, 8'h66, 8'h55, 1, 2'b00, 2'b00, 1, 8'h66);
    vecs[27] = mk(2'b00, 2'b00, 8'h66, 8'h55, 1, 2'b00, 2'b00, 0, 8'h66);

    do_reset();
    for (int i = 0; i < 28; i++) begin
      req_valid_i = vecs[i].valid;
      req_last_i  = vecs[i].last;
      req_data_i  = {vecs[i].d1, vecs[i].d0};
      in_ready_i  = vecs[i].rdy;
      #3;
      check($sformatf("row%0d_grant", i), 32'(grant_o),     32'(vecs[i].e_grant));
      check($sformatf("row%0d_ready", i), 32'(req_ready_o), 32'(vecs[i].e_ready));
      check($sformatf("row%0d_valid", i), 32'(in_valid_o),  32'(vecs[i].e_valid));
      check($sformatf("row%0d_data", i),  32'(in_data_o),   32'(vecs[i].e_data));
      step();
    end

    // Two requesters streaming continuously: alternating MAX_BURST bursts, requester 0 first.
    do_reset();
    cnt0 = 8'h00;
    cnt1 = 8'h80;
    got  = 0;
    for (int cyc = 0; cyc < 300 && got < 32; cyc++) begin
      req_data_i  = {cnt1, cnt0};
      req_valid_i = 2'b11;
      req_last_i  = 2'b00;
      in_ready_i  = 1'b1;
      #3;
      if (in_valid_o) begin
        check($sformatf("stream_%0d", got), 32'(in_data_o), 32'(stream_byte(got)));
        got++;
      end
      acc = req_valid_i & req_ready_o;
      step();
      if (acc[0]) cnt0 = cnt0 + 8'd1;
      if (acc[1]) cnt1 = cnt1 + 8'd1;
    end
    check("stream_count", got, 32);

    // Owner 0 idles after two bytes; release after exactly IDLE_TIMEOUT idle edges.
    do_reset();
    req_valid_i = 2'b01;
    req_data_i  = 16'h00A1;
    step();
    step();
    step();
    req_valid_i = 2'b10;
    req_data_i  = 16'hB000;
    n = 0;
    while (grant_o != 2'b00 && n < 40) begin
      step();
      n++;
    end
    check("timeout_edges", n, 16);
    step();
    check("timeout_next_grant", 32'(grant_o), 32'(2'b10));

    // Reset mid-burst drops the pending byte; requester 0 then wins a 0/1 tie.
    req_data_i = 16'hC300;
    step();
    in_ready_i  = 1'b0;
    req_valid_i = 2'b11;
    #3;
    check("pre_reset_valid", 32'(in_valid_o), 32'(1'b1));
    check("pre_reset_data",  32'(in_data_o),  32'(8'hC3));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #3;
    check("rst_grant", 32'(grant_o),     32'(2'b00));
    check("rst_ready", 32'(req_ready_o), 32'(2'b00));
    check("rst_valid", 32'(in_valid_o),  32'(1'b0));
    check("rst_data",  32'(in_data_o),   32'(8'h00));
    step();
    check("rst_tie_grant", 32'(grant_o), 32'(2'b01));

    // Requester 1 sends one byte 5A with last.
    do_reset();
    req_valid_i = 2'b10;
    req_last_i  = 2'b10;
    req_data_i  = 16'h5A00;
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #3;
      if (in_valid_o && got < 4) begin
        got_bytes[got] = in_data_o;
        got++;
      end
      acc = req_valid_i & req_ready_o;
      step();
      if (acc[1]) begin
        req_valid_i = 2'b00;
        req_last_i  = 2'b00;
      end
    end
`ifdef USB_CDC_ARB_TAG_EN
    check("tag_count", got, 2);
    check("tag_hdr",  32'(got_bytes[0]), 32'(8'hA1));
    check("tag_data", 32'(got_bytes[1]), 32'(8'h5A));
`else
    check("tag_count", got, 1);
    check("tag_data", 32'(got_bytes[0]), 32'(8'h5A));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/usb_cdc_in_arbiter.md
# usb_cdc_in_arbiter

Round-robin arbiter that shares the single USB CDC IN (device-to-host) byte stream between several application-side requesters. It sits between the application logic and the `in_data_i`/`in_valid_i`/`in_ready_o` port of `usb_cdc`, in the application clock domain. Each requester keeps the stream for a burst: until it marks a last byte, reaches a byte limit, or idles past a timeout. Bursts from different requesters never interleave.

## Interface
- `N_REQ`, default 2: number of requesters, 2..4.
- `MAX_BURST`, default 8: maximum bytes per grant, 1..255. Default matches the IN bulk max packet size.
- `IDLE_TIMEOUT`, default 16: consecutive idle cycles of the granted requester that force a release, 1..255.

Ports:
- `clk_i`  in  1: application clock; all logic on rising edge.
- `rst_i`  in  1: synchronous reset, active-high.
- `req_data_i`  in  8*N_REQ: byte of requester k at bits [8k+7:8k].
- `req_valid_i`  in  N_REQ: byte valid, one bit per requester.
- `req_last_i`  in  N_REQ: qualifies the current byte as end of message.
- `req_ready_o`  out  N_REQ: byte accepted when valid&ready on the same edge.
- `grant_o`  out  N_REQ: one-hot current owner; all zero when idle.
- `in_data_o`  out  8: to `usb_cdc` `in_data_i`.
- `in_valid_o`  out  1: to `usb_cdc` `in_valid_i`.
- `in_ready_i`  in  1: from `usb_cdc` `in_ready_o`.

## Operation
- States: IDLE, TAG (only with the tag feature), XFER.
- IDLE:
  - If any `req_valid_i` is high, grant the first valid requester, searching upward (wrapping) from `last_owner+1`.
  - Load `grant_o`; clear the burst counter and the idle counter.
  - Go to XFER, or to TAG when the tag feature is compiled in.
  - `last_owner` resets to N_REQ-1, so requester 0 wins first after reset.
- XFER:
  - `req_ready_o[k] = grant_o[k] & (~in_valid_o | in_ready_i)`; all other bits are 0.
  - Each accepted byte loads the output register. `in_valid_o` is set, the burst counter increments, and the idle counter clears.
  - Each cycle the granted requester has valid low, the idle counter increments.
  - Release means: return to IDLE, `last_owner` = owner, `grant_o` = 0. The owner releases on the edge that accepts:
    - a byte with `req_last_i` high, or
    - the MAX_BURST-th byte.
  - The owner also releases when the idle counter reaches IDLE_TIMEOUT.
- Output register: `in_valid_o` clears on `in_ready_i` when no new byte is loaded on the same edge.
- Pending byte after release: a byte still held in the output register is delivered normally.
  - A new grant may be issued in IDLE while it is pending.
  - The new owner's ready stays low until the register frees.
- Simultaneous requests: only the round-robin pointer decides; there are no fixed priorities.
- Non-owner requesters see ready 0 and must hold their data.
- Counter widths: 8 bits each. Comparisons are equality against the parameter value.

## Timing
- Reset values:
  - `grant_o`=0, `req_ready_o`=0.
  - `in_valid_o`=0, `in_data_o`=8'h00.
  - state IDLE, counters 0.
- Reset mid-burst drops the byte held in the output register.
- Arbitration latency: request seen in IDLE → `grant_o` and ready asserted the next cycle.
- Data latency: accepted byte appears on `in_data_o`/`in_valid_o` one cycle after acceptance.
- Throughput: one byte per cycle while `in_ready_i` stays high.
- Grant gap: at least one IDLE cycle between consecutive bursts.
- `in_valid_o` never drops without `in_ready_i`, and `in_data_o` is stable while valid and not ready.

## Configuration
- `USB_CDC_ARB_TAG_EN` defined:
  - On each grant the block enters TAG and loads header byte `8'hA0 | owner index` into the output register. This uses the same ready rule as data.
  - It then enters XFER. The header does not count toward MAX_BURST.
- Undefined: TAG is absent, IDLE goes directly to XFER, and no header bytes are emitted.

## Test plan
- Single requester 0 sends 3 bytes 11,22,33 with last on 33, `in_ready_i`=1 → `in_data_o` shows 11,22,33 on consecutive cycles, each one cycle after acceptance; `grant_o` returns to 0 after the last byte.
- Requesters 0 and 1 both stream continuously with `MAX_BURST`=8 → output alternates 8 bytes from 0, then 8 from 1, and so on; no interleave within a burst.
- `in_ready_i` held low for 5 cycles mid-burst → `in_data_o` and `in_valid_o` stable; owner ready low; no bytes lost or duplicated.
- Owner drops valid after 2 bytes with `IDLE_TIMEOUT`=16 → release exactly 16 idle cycles later; the waiting requester is granted the next cycle.
- `rst_i` pulsed for one cycle mid-burst → all outputs at reset values the next cycle; after reset, requester 0 wins a simultaneous 0/1 request.
- With `USB_CDC_ARB_TAG_EN`, requester 1 sends byte 5A → output A1 then 5A; without it → 5A only.
